// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: assembles 20-bit words from byte memory and issues them to the executor
// Optional build macro: FETCH_INSTR_COUNT_EN (enables the 16-bit retired-instruction counter on InstrCount)
module fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 20,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Run,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemData,
  output logic [OP_W-1:0]   OpCode,
  output logic              OpValid,
  input  logic              Done,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic              Halted,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_F0    = 3'd1,
    S_F1    = 3'd2,
    S_F2    = 3'd3,
    S_CAP   = 3'd4,
    S_ISSUE = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;

  // State, PC and instruction register; async reset drops every strobe at once
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state, memory strobes and byte capture (each byte lands one cycle after its read)
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    mem_read = 1'b0;
    mem_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_F0;
      end
      S_F0: begin
        mem_read = 1'b1;
        mem_addr = pc_q;
        state_d  = S_F1;
      end
      S_F1: begin
        mem_read      = 1'b1;
        mem_addr      = pc_q + ADDR_W'(1);
        opcode_d[7:0] = MemData[7:0];
        state_d       = S_F2;
      end
      S_F2: begin
        mem_read       = 1'b1;
        mem_addr       = pc_q + ADDR_W'(2);
        opcode_d[15:8] = MemData[7:0];
        state_d        = S_CAP;
      end
      S_CAP: begin
        // Only the low nibble of the third byte is part of the instruction
        opcode_d[19:16] = MemData[3:0];
        state_d         = (MemData[3:0] == HALT_OP) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        if (Done) begin
          pc_d    = Branch ? BranchAddr : (pc_q + ADDR_W'(3));
          state_d = Run ? S_F0 : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign MemRead = mem_read;
  assign MemAddr = mem_addr;
  assign OpCode  = opcode_q;
  assign OpValid = (state_q == S_ISSUE);
  assign Halted  = (state_q == S_HALT);
  assign PC      = pc_q;

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] count_q, count_d;

  // A retirement is a Done seen while an instruction is on offer
  always_comb begin
    count_d = count_q;
    if (state_q == S_ISSUE && Done) count_d = count_q + 16'd1;
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) count_q <= '0;
    else         count_q <= count_d;
  end

  assign InstrCount = count_q;
`else
  assign InstrCount = '0;
`endif

endmodule
